// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO subsystem: MMIO register
// addresses, the RAM page mask, STATUS bit positions and the address decoder.
package dmem_mmio_pkg;

  localparam logic [31:0] ADDR_GPIO     = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CYCLES   = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TXDATA   = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_STATUS   = 32'hFFFF_000C;

  // Any address with these bits clear lands in the RAM page.
  localparam logic [31:0] RAM_PAGE_MASK = 32'hFFFF_0000;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_CYCLES,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  // Byte-address bits [1:0] never take part in the decode: every access is a word.
  function automatic sel_e addr_decode(input logic [31:0] a);
    logic [31:0] a_w;
    sel_e        sel;
    a_w = {a[31:2], 2'b00};
    sel = SEL_NONE;
    if ((a_w & RAM_PAGE_MASK) == 32'h0) begin
      sel = SEL_RAM;
    end else begin
      case (a_w)
        ADDR_GPIO:   sel = SEL_GPIO;
        ADDR_CYCLES: sel = SEL_CYCLES;
        ADDR_TXDATA: sel = SEL_TXDATA;
        ADDR_STATUS: sel = SEL_STATUS;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core-side load/store bus plus the TX byte stream, bundled for dmem_mmio.
// slave = the memory subsystem, master = the core / TX consumer side.
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] gpio_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, gpio_out, tx_valid, tx_data
  );

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, gpio_out, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with registered output (no fall-through from din_i).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset flushes the FIFO without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an MMIO page holding
// GPIO, a free-running cycle counter and a byte TX FIFO. Loads are combinational.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  sel_e              sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       gpio_q, gpio_d;
  logic [31:0]       cycles_q, cycles_d;
  logic              ovf_q, ovf_d;
  logic              fifo_push, fifo_pop, fifo_drop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status_rd;

  assign sel     = addr_decode(bus.ALUResult);
  assign ram_idx = bus.ALUResult[RAM_AW+1:2];

  assign fifo_push = bus.MemWrite && (sel == SEL_TXDATA);
  assign fifo_pop  = bus.tx_ready && !fifo_empty;
  // Full with no pop: the byte is lost and flagged.
  assign fifo_drop = fifo_push && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (bus.WriteData[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_dout;
  assign bus.gpio_out = gpio_q;

  // Register next-state: a CYCLES write beats the increment; an overflow beats its W1C.
  always_comb begin
    gpio_d   = gpio_q;
    cycles_d = cycles_q + 32'd1;
    ovf_d    = ovf_q;
    if (bus.MemWrite && (sel == SEL_GPIO))   gpio_d   = bus.WriteData;
    if (bus.MemWrite && (sel == SEL_CYCLES)) cycles_d = 32'h0;
    if (bus.MemWrite && (sel == SEL_STATUS) && bus.WriteData[STAT_OVF]) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  // MMIO registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_q   <= '0;
      cycles_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycles_q <= cycles_d;
      ovf_q    <= ovf_d;
    end
  end

  // RAM is deliberately not reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && (sel == SEL_RAM)) ram_q[ram_idx] <= bus.WriteData;
  end

  // STATUS word assembly.
  always_comb begin
    status_rd                          = '0;
    status_rd[STAT_FULL]               = fifo_full;
    status_rd[STAT_EMPTY]              = fifo_empty;
    status_rd[STAT_OVF]                = ovf_q;
    status_rd[STAT_CNT_LSB +: 8]       = 8'(fifo_count);
  end

  // Zero-latency load mux; TXDATA and unmapped addresses read as 0.
  always_comb begin
    bus.ReadData = 32'h0;
    case (sel)
      SEL_RAM:    bus.ReadData = ram_q[ram_idx];
      SEL_GPIO:   bus.ReadData = gpio_q;
      SEL_CYCLES: bus.ReadData = cycles_q;
      SEL_STATUS: bus.ReadData = status_rd;
      default:    bus.ReadData = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: a queue/array model checked every cycle on the falling
// edge, plus directed checks with hand-computed values.
module tb_dmem_mmio;
  import dmem_mmio_pkg::*;

  localparam int RW = 64;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_mmio_if bus();

  dmem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]  m_ram    [RW];
  bit           m_ram_ok [RW];
  logic [31:0]  m_gpio = 0;
  logic [31:0]  m_cyc  = 0;
  bit           m_ovf  = 0;
  byte unsigned m_q[$];

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    known = 1'b1;
    if (w < 32'h0001_0000) begin
      known = m_ram_ok[(w >> 2) % RW];
      return m_ram[(w >> 2) % RW];
    end
    if (w == 32'hFFFF_0000) return m_gpio;
    if (w == 32'hFFFF_0004) return m_cyc;
    if (w == 32'hFFFF_000C)
      return (m_q.size() << 8) | (32'(m_ovf) << 2) | (32'(m_q.size() == 0) << 1)
             | 32'(m_q.size() == FD);
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] a, wd;
    bit we, pop, push, drop;
    if (reset) begin
      m_gpio = 0;
      m_cyc  = 0;
      m_ovf  = 0;
      m_q.delete();
    end else begin
      a    = bus.ALUResult & 32'hFFFF_FFFC;
      wd   = bus.WriteData;
      we   = bus.MemWrite;
      pop  = (m_q.size() > 0) && bus.tx_ready;
      push = we && (a == 32'hFFFF_0008);
      drop = push && (m_q.size() == FD) && !pop;
      m_cyc = (we && a == 32'hFFFF_0004) ? 32'h0 : m_cyc + 1;
      if (we && a == 32'hFFFF_0000) m_gpio = wd;
      if (we && a < 32'h0001_0000) begin
        m_ram[(a >> 2) % RW]    = wd;
        m_ram_ok[(a >> 2) % RW] = 1'b1;
      end
      if (we && a == 32'hFFFF_000C && wd[2]) m_ovf = 0;
      if (drop) m_ovf = 1;
      else begin
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(wd[7:0]);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit known;
    logic [31:0] exp;
    if (!reset) begin
      exp = m_read(bus.ALUResult, known);
      if (known) chk("rdata", bus.ReadData, exp);
      chk("gpio", bus.gpio_out, m_gpio);
      chk("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    bus.MemWrite  = we;
    bus.ALUResult = a;
    bus.WriteData = wd;
    bus.tx_ready  = rdy;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.ALUResult = a;
    #1;
    chk(nm, bus.ReadData, exp);
  endtask

  byte unsigned drain_exp [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h55};

  initial begin
    bus.MemWrite  = 1'b0;
    bus.ALUResult = ADDR_CYCLES;
    bus.WriteData = 32'h0;
    bus.tx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio", bus.gpio_out, 32'h0);
    chk("rst_txv", 32'(bus.tx_valid), 32'h0);
    peek("rst_status", ADDR_STATUS, 32'h0000_0002);
    bus.ALUResult = ADDR_CYCLES;
    reset = 1'b0;

    // cycle counter
    repeat (10) step(1'b0, ADDR_CYCLES, 32'h0, 1'b0);
    peek("cyc10", ADDR_CYCLES, 32'd10);
    step(1'b1, ADDR_CYCLES, 32'h1234_5678, 1'b0);
    peek("cyc_clr", ADDR_CYCLES, 32'd0);
    step(1'b0, ADDR_CYCLES, 32'h0, 1'b0);
    peek("cyc_one", ADDR_CYCLES, 32'd1);
    force dut.cycles_q = 32'hFFFF_FFFE;
    m_cyc = 32'hFFFF_FFFE;
    #1;
    release dut.cycles_q;
    peek("cyc_forced", ADDR_CYCLES, 32'hFFFF_FFFE);
    step(1'b0, ADDR_CYCLES, 32'h0, 1'b0);
    peek("cyc_max", ADDR_CYCLES, 32'hFFFF_FFFF);
    step(1'b0, ADDR_CYCLES, 32'h0, 1'b0);
    peek("cyc_wrap", ADDR_CYCLES, 32'h0);

    // RAM and unmapped space
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    peek("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    peek("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
    peek("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    peek("unmapped_rd", 32'h1234_0000, 32'h0);
    step(1'b1, 32'h1234_0000, 32'hCAFE_F00D, 1'b0);
    peek("unmapped_wr", 32'h1234_0000, 32'h0);
    peek("ram_intact", 32'h0000_0010, 32'hDEAD_BEEF);
    step(1'b1, 32'h0000_0014, 32'h0000_1111, 1'b0);
    // same-cycle store then load of one location: old value seen before the edge
    bus.MemWrite  = 1'b1;
    bus.ALUResult = 32'h0000_0014;
    bus.WriteData = 32'h0000_2222;
    #1;
    chk("ram_old_val", bus.ReadData, 32'h0000_1111);
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    peek("ram_new_val", 32'h0000_0014, 32'h0000_2222);

    // GPIO and reset
    step(1'b1, ADDR_GPIO, 32'h0000_00A5, 1'b0);
    chk("gpio_set", bus.gpio_out, 32'h0000_00A5);
    peek("gpio_rd", ADDR_GPIO, 32'h0000_00A5);
    reset = 1'b1;
    #1;
    chk("gpio_async_rst", bus.gpio_out, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    peek("ram_keeps", 32'h0000_0010, 32'hDEAD_BEEF);

    // TX FIFO fill, overflow, W1C
    step(1'b1, ADDR_TXDATA, 32'h0000_0041, 1'b0);
    chk("tx_v1", 32'(bus.tx_valid), 32'h1);
    chk("tx_d1", 32'(bus.tx_data), 32'h41);
    peek("st_one", ADDR_STATUS, 32'h0000_0100);
    peek("txdata_rd0", ADDR_TXDATA, 32'h0);
    for (int i = 0; i < 7; i++) step(1'b1, ADDR_TXDATA, 32'h42 + i, 1'b0);
    peek("st_full", ADDR_STATUS, 32'h0000_0801);
    step(1'b1, ADDR_TXDATA, 32'h0000_0049, 1'b0);
    peek("st_ovf", ADDR_STATUS, 32'h0000_0805);
    chk("tx_hold", 32'(bus.tx_data), 32'h41);
    step(1'b1, ADDR_STATUS, 32'h0000_0004, 1'b0);
    peek("st_w1c", ADDR_STATUS, 32'h0000_0801);

    // full with simultaneous pop, then drain
    step(1'b1, ADDR_TXDATA, 32'h0000_0055, 1'b1);
    peek("st_full_pop", ADDR_STATUS, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      chk("drain_v", 32'(bus.tx_valid), 32'h1);
      chk("drain_d", 32'(bus.tx_data), 32'(drain_exp[i]));
      step(1'b0, ADDR_STATUS, 32'h0, 1'b1);
    end
    chk("drain_empty", 32'(bus.tx_valid), 32'h0);
    peek("st_empty", ADDR_STATUS, 32'h0000_0002);

    // push into empty FIFO with tx_ready high: nothing pops that cycle
    step(1'b1, ADDR_TXDATA, 32'h0000_0077, 1'b1);
    chk("push_empty_v", 32'(bus.tx_valid), 32'h1);
    chk("push_empty_d", 32'(bus.tx_data), 32'h77);
    step(1'b0, ADDR_STATUS, 32'h0, 1'b1);
    chk("push_empty_pop", 32'(bus.tx_valid), 32'h0);

    // reset with bytes queued
    for (int i = 0; i < 3; i++) step(1'b1, ADDR_TXDATA, 32'h10 + i, 1'b0);
    chk("q3_v", 32'(bus.tx_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_txv_async", 32'(bus.tx_valid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    peek("st_after_rst", ADDR_STATUS, 32'h0000_0002);
    peek("cyc_restart", ADDR_CYCLES, 32'h0);
    step(1'b0, ADDR_CYCLES, 32'h0, 1'b0);
    peek("cyc_restart1", ADDR_CYCLES, 32'h1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
